// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit datapath: opcode constants, instruction
// field positions and fetch sequencer state encoding.
package cpu16_pkg;

    localparam logic [3:0] OP_LI   = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_ANDI = 4'hA;
    localparam logic [3:0] OP_ORI  = 4'hB;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned IMM_MSB = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    function automatic logic is_imm_op(input logic [3:0] op);
        return (op == OP_LI) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for the fetch sequencer; tc flags the last permitted
// cycle without mem_ready.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_reg.sv
// Instruction fetch sequencer and instruction register; splits the captured
// word into opcode/rd/imm8 and holds it under a valid/stall handshake.
module instr_fetch_reg
    import cpu16_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_start,
    input  logic [15:0] pc_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        stall,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] instr_out,
    output logic [3:0]  opcode,
    output logic [3:0]  rd,
    output logic [7:0]  imm8,
    output logic        imm_used,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_fault
);

    fetch_state_t state, state_nxt;
    logic [15:0]  ir, ir_nxt;
    logic [15:0]  addr, addr_nxt;
    logic         fault_nxt;
    logic         ctr_clear, ctr_en, ctr_tc;

    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_ctr (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (ctr_clear),
        .enable (ctr_en),
        .tc     (ctr_tc)
    );

    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        addr_nxt  = addr;
        fault_nxt = 1'b0;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_start) begin
                    addr_nxt  = pc_in;
                    ctr_clear = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // a response on the terminal-count cycle still wins over the fault
                if (mem_ready) begin
                    ir_nxt    = mem_rdata;
                    state_nxt = VALID;
                end else if (ctr_tc) begin
                    fault_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            VALID: begin
                if (!stall) begin
                    if (fetch_start) begin
                        addr_nxt  = pc_in;
                        ctr_clear = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            ir          <= '0;
            addr        <= '0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nxt;
            ir          <= ir_nxt;
            addr        <= addr_nxt;
            fetch_fault <= fault_nxt;
        end
    end

    assign mem_req     = (state == WAIT);
    assign instr_valid = (state == VALID);
    assign busy        = (state != IDLE);
    assign mem_addr    = addr;
    assign instr_out   = ir;
    assign opcode      = ir[OPC_MSB -: 4];
    assign rd          = ir[RD_MSB -: 4];
    assign imm8        = ir[IMM_MSB:0];
    assign imm_used    = instr_valid && is_imm_op(opcode);

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Self-checking bench for instr_fetch_reg: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_instr_fetch_reg;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        reset_n;
    logic        fetch_start;
    logic [15:0] pc_in;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] instr_out;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [7:0]  imm8;
    logic        imm_used;
    logic        instr_valid;
    logic        busy;
    logic        fetch_fault;

    int unsigned total = 0;
    int unsigned bad   = 0;

    instr_fetch_reg #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_start(fetch_start),
        .pc_in      (pc_in),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .instr_out  (instr_out),
        .opcode     (opcode),
        .rd         (rd),
        .imm8       (imm8),
        .imm_used   (imm_used),
        .instr_valid(instr_valid),
        .busy       (busy),
        .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a fetch is either outstanding, delivered, or absent.
    bit          m_outstanding;
    bit          m_delivered;
    int          m_waited;
    logic [15:0] m_ir;
    logic [15:0] m_addr;
    bit          m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit fs, input logic [15:0] pc,
                                input logic [15:0] rdata, input bit rdy, input bit st);
        m_fault = 0;
        if (!r) begin
            m_outstanding = 0;
            m_delivered   = 0;
            m_waited      = 0;
            m_ir          = 16'h0;
            m_addr        = 16'h0;
        end else if (m_outstanding) begin
            if (rdy) begin
                m_ir          = rdata;
                m_outstanding = 0;
                m_delivered   = 1;
            end else if (m_waited + 1 == TIMEOUT) begin
                m_outstanding = 0;
                m_fault       = 1;
            end else begin
                m_waited++;
            end
        end else if (m_delivered) begin
            if (!st) begin
                m_delivered = 0;
                if (fs) begin
                    m_addr = pc; m_outstanding = 1; m_waited = 0;
                end
            end
        end else if (fs) begin
            m_addr = pc; m_outstanding = 1; m_waited = 0;
        end
    endtask

    task automatic compare_all();
        int op;
        op = int'(m_ir) / 4096;
        check("mem_req",     32'(mem_req),     32'(m_outstanding));
        check("busy",        32'(busy),        32'(m_outstanding || m_delivered));
        check("instr_valid", 32'(instr_valid), 32'(m_delivered));
        check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        check("mem_addr",    32'(mem_addr),    32'(m_addr));
        check("instr_out",   32'(instr_out),   32'(m_ir));
        check("opcode",      32'(opcode),      32'(op));
        check("rd",          32'(rd),          32'((int'(m_ir) / 256) % 16));
        check("imm8",        32'(imm8),        32'(int'(m_ir) % 256));
        check("imm_used",    32'(imm_used),    32'(m_delivered && op >= 8 && op <= 11));
    endtask

    task automatic step(input bit r, input bit fs, input logic [15:0] pc,
                        input logic [15:0] rdata, input bit rdy, input bit st);
        reset_n     = r;
        fetch_start = fs;
        pc_in       = pc;
        mem_rdata   = rdata;
        mem_ready   = rdy;
        stall       = st;
        @(posedge clk);
        model_update(r, fs, pc, rdata, rdy, st);
        #1;
        compare_all();
    endtask

    initial begin
        int unsigned rdy_pct;
        reset_n = 0; fetch_start = 0; pc_in = '0; mem_rdata = '0; mem_ready = 0; stall = 0;

        // reset
        step(0, 0, 16'h0, 16'h0, 0, 0);
        step(0, 1, 16'hFFFF, 16'hFFFF, 1, 0);
        check("rst_ir", 32'(instr_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // basic fetch, response three cycles into the request
        step(1, 1, 16'h0040, 16'h0, 0, 0);
        check("req_after_start", 32'(mem_req), 32'h1);
        step(1, 0, 16'h0, 16'hDEAD, 0, 0);
        step(1, 0, 16'h0, 16'hBEEF, 0, 0);
        step(1, 0, 16'h0, 16'h93A5, 1, 0);
        check("f1_addr", 32'(mem_addr), 32'h0040);
        check("f1_valid", 32'(instr_valid), 32'h1);
        check("f1_opcode", 32'(opcode), 32'h9);
        check("f1_rd", 32'(rd), 32'h3);
        check("f1_imm8", 32'(imm8), 32'hA5);
        check("f1_imm_used", 32'(imm_used), 32'h1);

        // stall holds the instruction while memory data churns
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 16'($urandom), 16'($urandom), 1'($urandom), 1);
            check("stall_ir", 32'(instr_out), 32'h93A5);
            check("stall_req", 32'(mem_req), 32'h0);
        end

        // timeout: TIMEOUT cycles of request with no response
        step(1, 0, 16'h0, 16'h0, 0, 0);
        step(1, 1, 16'h0100, 16'h0, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 1, 16'h0, 16'($urandom), 0, 0);
        check("pre_tc_fault", 32'(fetch_fault), 32'h0);
        step(1, 0, 16'h0, 16'h0, 0, 0);
        check("to_fault", 32'(fetch_fault), 32'h1);
        check("to_req", 32'(mem_req), 32'h0);
        check("to_ir", 32'(instr_out), 32'h93A5);
        step(1, 0, 16'h0, 16'h0, 0, 0);
        check("to_pulse_end", 32'(fetch_fault), 32'h0);

        // response on the terminal-count cycle
        step(1, 1, 16'h0200, 16'h0, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 16'h0, 16'h0, 0, 0);
        step(1, 0, 16'h0, 16'h1234, 1, 0);
        check("tc_fault", 32'(fetch_fault), 32'h0);
        check("tc_valid", 32'(instr_valid), 32'h1);
        check("tc_imm_used", 32'(imm_used), 32'h0);

        // back-to-back fetch from VALID
        step(1, 1, 16'h0041, 16'h0, 0, 0);
        check("b2b_req", 32'(mem_req), 32'h1);
        check("b2b_addr", 32'(mem_addr), 32'h0041);
        check("b2b_valid", 32'(instr_valid), 32'h0);
        check("b2b_busy", 32'(busy), 32'h1);

        // reset while waiting; the late response must be dropped
        step(0, 0, 16'h0, 16'h0, 0, 0);
        step(1, 0, 16'h0, 16'hB777, 1, 0);
        check("late_ir", 32'(instr_out), 32'h0);
        check("late_valid", 32'(instr_valid), 32'h0);
        check("late_busy", 32'(busy), 32'h0);

        // randomized traffic, alternating sparse and dense memory responses
        rdy_pct = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) rdy_pct = (rdy_pct == 30) ? 3 : 30;
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 2) == 0),
                 16'($urandom),
                 16'($urandom),
                 ($urandom_range(0, 99) < rdy_pct),
                 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
